// File: rtl/shifter_pkg.sv
// Shared definitions for the shifter family of blocks.
//   N       : datapath width (only 32 is supported)
//   SHW     : width of a shift amount for an N-bit word
//   state_t : control states of the iterative shifter
package shifter_pkg;

  localparam int N   = 32;
  localparam int SHW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_stage.sv
// One conditional left-shift stage of the iterative shifter.
// Shifts the word left by 2^k when enabled, filling zeros from bit 0;
// passes the word through unchanged otherwise.
// Ports:
//   enable  : 1 = apply the shift, 0 = pass through
//   k       : stage index 0..4, selecting a shift of 1, 2, 4, 8 or 16
//   word    : 32-bit word to shift
//   shifted : 32-bit result
module shift_stage
  import shifter_pkg::*;
(
  input  logic         enable,
  input  logic [2:0]   k,
  input  logic [N-1:0] word,
  output logic [N-1:0] shifted
);

  // Each stage amount is a fixed rewiring; bits leaving bit 31 are dropped.
  // Unused index values (5..7) pass the word through.
  always_comb begin
    shifted = word;
    if (enable) begin
      case (k)
        3'd0:    shifted = {word[N-2:0],  1'b0};
        3'd1:    shifted = {word[N-3:0],  2'b0};
        3'd2:    shifted = {word[N-5:0],  4'b0};
        3'd3:    shifted = {word[N-9:0],  8'b0};
        3'd4:    shifted = {word[N-17:0], 16'b0};
        default: shifted = word;
      endcase
    end
  end

endmodule

// File: rtl/shift_left_iterative.sv
// Iterative logical left shifter with valid/ready handshakes.
// An accepted operand is shifted over five cycles, one power-of-two stage
// per cycle (16, 8, 4, 2, 1), then held as the result until taken.
// Ports:
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   in_valid  : upstream operand valid
//   in_ready  : block can accept an operand (IDLE)
//   in        : operand to shift
//   shamt     : shift amount 0..31
//   out_valid : result valid (DONE)
//   out_ready : downstream accepts the result
//   out       : shifted result, zero outside DONE
module shift_left_iterative
  import shifter_pkg::*;
#(
  parameter int N = shifter_pkg::N
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in,
  input  logic [$clog2(N)-1:0] shamt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out
);

  state_t               state_r;
  logic [N-1:0]         work_r;
  logic [$clog2(N)-1:0] shamt_r;
  logic [2:0]           k_r;

  logic                 stage_enable;
  logic [N-1:0]         stage_word;

  // The stage applies 2^k only when the matching bit of the latched
  // shift amount is set; k walks from 4 down to 0.
  assign stage_enable = shamt_r[k_r];

  shift_stage u_stage (
    .enable  (stage_enable),
    .k       (k_r),
    .word    (work_r),
    .shifted (stage_word)
  );

  // Control and datapath state. SHIFT always runs all five stages, even
  // for a zero shift amount, so the latency is fixed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      work_r  <= '0;
      shamt_r <= '0;
      k_r     <= 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            work_r  <= in;
            shamt_r <= shamt;
            k_r     <= 3'd4;
            state_r <= SHIFT;
          end
        end
        SHIFT: begin
          work_r <= stage_word;
          if (k_r == 3'd0) begin
            state_r <= DONE;
          end else begin
            k_r <= k_r - 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Handshake flags and the result are pure decodes of the state register.
  always_comb begin
    in_ready  = (state_r == IDLE);
    out_valid = (state_r == DONE);
    out       = (state_r == DONE) ? work_r : '0;
  end

endmodule

// File: tb/tb_shift_left_iterative.sv
// Directed self-checking bench for shift_left_iterative.
module tb_shift_left_iterative;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;

  int check_count = 0;
  int pass_count  = 0;

  shift_left_iterative #(.N(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_word),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_word)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one operation from IDLE. hold = cycles out_ready stays low in DONE;
  // noise = drive a competing operand while the shift is in flight.
  task automatic applyStimulus(input string tag, input logic [31:0] operand,
                               input logic [4:0] amount, input int hold,
                               input bit noise, input logic [31:0] expected);
    int lat;
    checkOutput({tag, "_idle_ready"}, {31'b0, in_ready}, 32'd1);
    in_word   = operand;
    shamt     = amount;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    tick();
    in_valid = 1'b0;
    checkOutput({tag, "_busy_ready"}, {31'b0, in_ready}, 32'd0);
    if (noise) begin
      in_word  = 32'h1234_5678;
      shamt    = 5'd31;
      in_valid = 1'b1;
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    in_valid = 1'b0;
    checkOutput({tag, "_latency"}, lat, 32'd5);
    checkOutput({tag, "_out"}, out_word, expected);
    checkOutput({tag, "_done_ready"}, {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      checkOutput({tag, "_hold_out"}, out_word, expected);
      checkOutput({tag, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
      checkOutput({tag, "_hold_ready"}, {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    checkOutput({tag, "_after_valid"}, {31'b0, out_valid}, 32'd0);
    checkOutput({tag, "_after_ready"}, {31'b0, in_ready}, 32'd1);
    checkOutput({tag, "_after_out"}, out_word, 32'h0);
    if (noise) begin
      tick();
      checkOutput({tag, "_no_queue"}, {31'b0, in_ready}, 32'd1);
    end
  endtask

  // Back-to-back vectors with hand-computed results.
  logic [31:0] bb_in  [3] = '{32'h0000_0003, 32'h8000_0001, 32'h00FF_00FF};
  logic [4:0]  bb_amt [3] = '{5'd1, 5'd1, 5'd8};
  logic [31:0] bb_exp [3] = '{32'h0000_0006, 32'h0000_0002, 32'hFF00_FF00};

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc_cyc [3];
    int out_cyc [3];
    logic [31:0] got [3];
    int na;
    int no;
    bit prev_ready;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_word   = 32'h0;
    shamt     = 5'd0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_out", out_word, 32'h0);

    $display("[TB] directed vectors");
    applyStimulus("max_shift", 32'h0000_0001, 5'd31, 0, 1'b0, 32'h8000_0000);
    applyStimulus("zero_shift", 32'hDEAD_BEEF, 5'd0, 0, 1'b0, 32'hDEAD_BEEF);
    applyStimulus("backpressure", 32'hFFFF_FFFF, 5'd16, 3, 1'b0, 32'hFFFF_0000);
    applyStimulus("ignore_second", 32'h0000_00F0, 5'd4, 0, 1'b1, 32'h0000_0F00);
    applyStimulus("truncate", 32'h1234_5678, 5'd5, 0, 1'b0, 32'h468A_CF00);
    applyStimulus("mixed_stages", 32'hA5A5_A5A5, 5'd21, 0, 1'b0, 32'hB4A0_0000);

    $display("[TB] reset during shift");
    in_word  = 32'h0000_ABCD;
    shamt    = 5'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midrst_out", out_word, 32'h0);
    applyStimulus("post_reset", 32'h0000_0001, 5'd4, 0, 1'b0, 32'h0000_0010);

    $display("[TB] valid during reset");
    in_word  = 32'h0000_0077;
    shamt    = 5'd2;
    in_valid = 1'b1;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    checkOutput("rst_valid_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    checkOutput("rst_valid_still_idle", {31'b0, in_ready}, 32'd1);

    $display("[TB] back-to-back");
    na = 0;
    no = 0;
    in_word    = bb_in[0];
    shamt      = bb_amt[0];
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    prev_ready = in_ready;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (prev_ready && in_valid) begin
        acc_cyc[na] = c;
        na++;
        if (na < 3) begin
          in_word = bb_in[na];
          shamt   = bb_amt[na];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        if (no < 3) begin
          got[no]     = out_word;
          out_cyc[no] = c;
        end
        no++;
      end
      prev_ready = in_ready;
    end
    checkOutput("bb_accepts", na, 32'd3);
    checkOutput("bb_pulses", no, 32'd3);
    if (na == 3 && no == 3) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("bb_result%0d", i), got[i], bb_exp[i]);
        checkOutput($sformatf("bb_latency%0d", i), out_cyc[i] - acc_cyc[i], 32'd5);
      end
      checkOutput("bb_gap01", acc_cyc[1] - acc_cyc[0], 32'd7);
      checkOutput("bb_gap12", acc_cyc[2] - acc_cyc[1], 32'd7);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
